// File: rtl/load_store_unit.sv
// Byte-addressed load/store front-end for a 512x32 synchronous word memory.
// Ports: req_* request handshake from execute, resp_* completion pulse,
// mem_* to/from the word memory (registered read, one-cycle read latency).
module load_store_unit #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_store,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_address,
    output logic [DATA_W-1:0] mem_data_input,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_output
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR       = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]  state;
    logic [1:0]  lane_q;
    logic [15:0] wd_q;
    logic [1:0]  size_q;
    logic        store_q;
    logic        signed_q;

    logic        req_bad;
    logic        req_wstore;
    logic [31:0] load_val;
    logic [31:0] merge_val;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign req_ready = (state == IDLE);

    // Sub-word requests that cannot be served are rejected up front.
    always_comb begin
        req_bad    = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_store && req_size == 2'b10
                       && req_addr[1:0] != 2'b00);
        req_wstore = req_store && (req_size == 2'b10);
    end

    // Lane extraction and merge operate on the word arriving this cycle.
    always_comb begin
        rd_byte = 8'h00;
        unique case (lane_q)
            2'd0: rd_byte = mem_data_output[7:0];
            2'd1: rd_byte = mem_data_output[15:8];
            2'd2: rd_byte = mem_data_output[23:16];
            2'd3: rd_byte = mem_data_output[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half = lane_q[1] ? mem_data_output[31:16]
                            : mem_data_output[15:0];

        load_val = 32'h0;
        unique case (size_q)
            2'b00: load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01: load_val = {{16{signed_q & rd_half[15]}}, rd_half};
            default: begin
                // Unaligned word load rotates right by the byte offset.
                unique case (lane_q)
                    2'd0: load_val = mem_data_output;
                    2'd1: load_val = {mem_data_output[7:0],
                                      mem_data_output[31:8]};
                    2'd2: load_val = {mem_data_output[15:0],
                                      mem_data_output[31:16]};
                    2'd3: load_val = {mem_data_output[23:0],
                                      mem_data_output[31:24]};
                    default: load_val = mem_data_output;
                endcase
            end
        endcase

        merge_val = mem_data_output;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'd0: merge_val[7:0]   = wd_q[7:0];
                2'd1: merge_val[15:8]  = wd_q[7:0];
                2'd2: merge_val[23:16] = wd_q[7:0];
                2'd3: merge_val[31:24] = wd_q[7:0];
                default: merge_val = mem_data_output;
            endcase
        end else if (lane_q[1]) begin
            merge_val[31:16] = wd_q;
        end else begin
            merge_val[15:0] = wd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lane_q         <= 2'b00;
            wd_q           <= 16'h0;
            size_q         <= 2'b00;
            store_q        <= 1'b0;
            signed_q       <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_address    <= '0;
            mem_data_input <= '0;
            mem_write      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            mem_write  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lane_q   <= req_addr[1:0];
                        wd_q     <= req_wdata[15:0];
                        size_q   <= req_size;
                        store_q  <= req_store;
                        signed_q <= req_signed;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            mem_address <= req_addr[ADDR_W-1:2];
                            if (req_wstore) begin
                                mem_data_input <= req_wdata;
                                mem_write      <= 1'b1;
                                state          <= WR;
                            end else begin
                                state <= RD_ISSUE;
                            end
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (store_q) begin
                        mem_data_input <= merge_val;
                        mem_write      <= 1'b1;
                        state          <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_val;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-memory model and
// a per-cycle checker against a spec-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_store, req_signed;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [8:0]  mem_address;
    logic [31:0] mem_data_input, mem_data_output;
    logic        mem_write;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_store(req_store),
        .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_address(mem_address), .mem_data_input(mem_data_input),
        .mem_write(mem_write), .mem_data_output(mem_data_output)
    );

    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_data_input;
        mem_data_output <= mem[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int exp_resp = -1;
    int exp_wr = -1;
    int busy_lo = -1;
    int busy_hi = -2;
    logic [31:0] exp_rdata, exp_wdata, last_rdata;
    logic        exp_err;
    logic [8:0]  exp_waddr;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] m_load(logic [31:0] w, logic [10:0] a,
                                           logic [1:0] sz, logic sg);
        logic [31:0] v;
        logic [63:0] ww;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 16 : 0;
            v = (w >> sh) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            sh = 8 * int'(a[1:0]);
            ww = {w, w} >> sh;
            v = ww[31:0];
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] old, logic [31:0] wd,
                                            logic [10:0] a, logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) return wd;
        mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        sh = (sz == 2'b00) ? 8 * int'(a[1:0]) : (a[1] ? 16 : 0);
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    always @(negedge clk) begin
        check("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == exp_resp});
        check("mem_write", {31'b0, mem_write}, {31'b0, cyc == exp_wr});
        check("req_ready", {31'b0, req_ready},
              {31'b0, !(cyc >= busy_lo && cyc <= busy_hi)});
        if (resp_valid) begin
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
            last_rdata = resp_rdata;
        end
        if (mem_write) begin
            check("mem_address", {23'b0, mem_address}, {23'b0, exp_waddr});
            check("mem_data_input", mem_data_input, exp_wdata);
        end
    end

    task automatic do_req(logic [10:0] a, logic [31:0] wd, logic [1:0] sz,
                          logic st, logic sg, bit spam);
        int t, lat;
        logic err;
        logic [8:0] idx;
        logic [31:0] w;
        @(negedge clk);
        t = cyc;
        idx = a[10:2];
        w = ref_mem[idx];
        err = (sz == 2'b11) || (sz == 2'b01 && a[0])
            || (st && sz == 2'b10 && a[1:0] != 2'b00);
        if (err) lat = 1;
        else if (st && sz == 2'b10) lat = 2;
        else if (st) lat = 4;
        else lat = 3;
        exp_err = err;
        exp_rdata = (err || st) ? 32'h0 : m_load(w, a, sz, sg);
        exp_waddr = idx;
        exp_wdata = m_store(w, wd, a, sz);
        exp_wr = (st && !err) ? t + lat - 1 : -1;
        if (st && !err) ref_mem[idx] = exp_wdata;
        exp_resp = t + lat;
        busy_lo = t + 1;
        busy_hi = t + lat;
        req_valid = 1'b1;
        req_addr = a;
        req_wdata = wd;
        req_size = sz;
        req_store = st;
        req_signed = sg;
        @(negedge clk);
        if (spam) begin
            req_addr = 11'h000;
            req_wdata = 32'h5A5A_5A5A;
            req_size = 2'b10;
            req_store = 1'b1;
        end else begin
            req_valid = 1'b0;
        end
        while (cyc < t + lat) @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_size = '0;
        req_store = 1'b0;
        req_signed = 1'b0;
        last_rdata = '0;
        exp_rdata = '0;
        exp_wdata = '0;
        exp_err = 1'b0;
        exp_waddr = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[5] = 32'h1122_3344;
        ref_mem[5] = 32'h1122_3344;
        @(negedge clk);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'b0, resp_err}, 32'h0);
        check("rst_addr", {23'b0, mem_address}, 32'h0);
        check("rst_wdata", mem_data_input, 32'h0);
        #2 rst = 1'b0;

        do_req(11'h015, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1 check("lit_lb", last_rdata, 32'h0000_0033);
        do_req(11'h016, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0);
        #1 check("lit_lh_pos", last_rdata, 32'h0000_1122);
        mem[5] = 32'h8000_0000;
        ref_mem[5] = 32'h8000_0000;
        do_req(11'h016, 32'h0, 2'b01, 1'b0, 1'b1, 1'b1);
        #1 check("lit_lh_neg", last_rdata, 32'hFFFF_8000);
        mem[5] = 32'h1122_3344;
        ref_mem[5] = 32'h1122_3344;
        do_req(11'h017, 32'h0000_00AB, 2'b00, 1'b1, 1'b0, 1'b0);
        do_req(11'h014, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
        #1 check("lit_sb_rb", last_rdata, 32'hAB22_3344);
        do_req(11'h020, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 1'b0);
        do_req(11'h021, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
        #1 check("lit_lw_rot", last_rdata, 32'hEFDE_ADBE);
        do_req(11'h013, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0);
        do_req(11'h010, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
        do_req(11'h022, 32'h1234_5678, 2'b10, 1'b1, 1'b0, 1'b0);
        do_req(11'h014, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        #1 check("lit_after_err", last_rdata, 32'h0000_0044);
        do_req(11'h022, 32'h0000_CAFE, 2'b01, 1'b1, 1'b0, 1'b1);
        do_req(11'h023, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        #1 check("lit_lb_neg", last_rdata, 32'hFFFF_FFCA);
        check("lit_mem8", mem[8], 32'hCAFE_BEEF);

        // Byte store interrupted by reset in RD_WAIT.
        @(negedge clk);
        busy_lo = cyc + 1;
        busy_hi = cyc + 2;
        exp_resp = -1;
        exp_wr = -1;
        req_valid = 1'b1;
        req_addr = 11'h015;
        req_wdata = 32'h0000_0077;
        req_size = 2'b00;
        req_store = 1'b1;
        req_signed = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        busy_lo = -1;
        busy_hi = -2;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mem5", mem[5], ref_mem[5]);
        check("lit_rst_mem5", mem[5], 32'hAB22_3344);
        do_req(11'h015, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1 check("lit_post_rst", last_rdata, 32'h0000_0033);

        check("final_mem5", mem[5], ref_mem[5]);
        check("final_mem8", mem[8], ref_mem[8]);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
